// File: rtl/mem_arbiter_pkg.sv
// Shared widths, state/owner encodings and the latched memory command for mem_arbiter.
// Also carries the shared defines (`PC_WIDTH, `IWIDTH, `DWIDTH, MA_* encodings).
`ifndef MEM_ARBITER_DEFINES
`define MEM_ARBITER_DEFINES
`define PC_WIDTH  32
`define IWIDTH    32
`define DWIDTH    32
`define MA_IDLE   2'd0
`define MA_BUSY   2'd1
`define MA_RESP   2'd2
`define MA_OWN_IF 1'b0
`define MA_OWN_DM 1'b1
`endif

package mem_arbiter_pkg;
   localparam int unsigned PC_W   = `PC_WIDTH;
   localparam int unsigned IW     = `IWIDTH;
   localparam int unsigned DW     = `DWIDTH;
   localparam int unsigned MASK_W = 4;
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned PERF_W = 16;

   typedef enum logic [1:0] {
      MA_ST_IDLE = `MA_IDLE,
      MA_ST_BUSY = `MA_BUSY,
      MA_ST_RESP = `MA_RESP
   } ma_state_t;

   typedef enum logic {
      OWN_IF = `MA_OWN_IF,
      OWN_DM = `MA_OWN_DM
   } ma_owner_t;

   typedef struct packed {
      logic              we;
      logic [MASK_W-1:0] mask;
      logic [DW-1:0]     addr;
      logic [DW-1:0]     wdata;
   } ma_mem_cmd_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// Pipeline and backing-memory signals of mem_arbiter; slave = arbiter side.
// MEM_ARBITER_PERF_CNT_EN adds the two wait-cycle counters.
interface mem_arbiter_if;
   import mem_arbiter_pkg::*;

   logic              ma_i_if_req;
   logic [PC_W-1:0]   ma_i_if_addr;
   logic              ma_o_if_ack;
   logic [IW-1:0]     ma_o_if_instr;
   logic              ma_i_dm_req;
   logic              ma_i_dm_we;
   logic [MASK_W-1:0] ma_i_dm_mask;
   logic [DW-1:0]     ma_i_dm_addr;
   logic [DW-1:0]     ma_i_dm_wdata;
   logic              ma_o_dm_ack;
   logic [DW-1:0]     ma_o_dm_rdata;
   logic              ma_o_mem_req;
   logic              ma_o_mem_we;
   logic [MASK_W-1:0] ma_o_mem_mask;
   logic [DW-1:0]     ma_o_mem_addr;
   logic [DW-1:0]     ma_o_mem_wdata;
   logic              ma_i_mem_ack;
   logic [DW-1:0]     ma_i_mem_rdata;
   logic              ma_o_stall;
   logic              ma_o_err;
`ifdef MEM_ARBITER_PERF_CNT_EN
   logic [PERF_W-1:0] ma_o_if_wait_cnt;
   logic [PERF_W-1:0] ma_o_dm_wait_cnt;
`endif

   modport slave (
      input  ma_i_if_req, ma_i_if_addr, ma_i_dm_req, ma_i_dm_we, ma_i_dm_mask,
             ma_i_dm_addr, ma_i_dm_wdata, ma_i_mem_ack, ma_i_mem_rdata,
      output ma_o_if_ack, ma_o_if_instr, ma_o_dm_ack, ma_o_dm_rdata, ma_o_mem_req,
             ma_o_mem_we, ma_o_mem_mask, ma_o_mem_addr, ma_o_mem_wdata, ma_o_stall,
             ma_o_err
`ifdef MEM_ARBITER_PERF_CNT_EN
      , output ma_o_if_wait_cnt, ma_o_dm_wait_cnt
`endif
   );

   modport master (
      output ma_i_if_req, ma_i_if_addr, ma_i_dm_req, ma_i_dm_we, ma_i_dm_mask,
             ma_i_dm_addr, ma_i_dm_wdata, ma_i_mem_ack, ma_i_mem_rdata,
      input  ma_o_if_ack, ma_o_if_instr, ma_o_dm_ack, ma_o_dm_rdata, ma_o_mem_req,
             ma_o_mem_we, ma_o_mem_mask, ma_o_mem_addr, ma_o_mem_wdata, ma_o_stall,
             ma_o_err
`ifdef MEM_ARBITER_PERF_CNT_EN
      , input ma_o_if_wait_cnt, ma_o_dm_wait_cnt
`endif
   );
endinterface

// File: rtl/mem_arbiter_grant_sel.sv
// Grant owner select: data wins unless fetch is starved or data is not requesting.
module ma_grant_sel
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic             if_req,
   input  logic             dm_req,
   input  logic [CNT_W-1:0] starve_cnt,
   output ma_owner_t        owner_c
);
   always_comb begin
      owner_c = OWN_DM;
      if (!dm_req || (if_req && (starve_cnt == CNT_W'(STARVE_LIMIT))))
         owner_c = OWN_IF;
   end
endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data ports.
// Optional wait-cycle counters under MEM_ARBITER_PERF_CNT_EN.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned TIMEOUT      = 64
) (
   input  logic          ma_clk,
   input  logic          ma_rst,
   mem_arbiter_if.slave  bus
);
   localparam int unsigned TMO_W = $clog2(TIMEOUT);

   ma_state_t        state_q;
   ma_owner_t        owner_q;
   ma_owner_t        gnt_owner_c;
   ma_mem_cmd_t      cmd_q;
   ma_mem_cmd_t      next_cmd_c;
   logic [CNT_W-1:0] starve_cnt_q;
   logic [TMO_W-1:0] tmo_cnt_q;
   logic             mem_req_q;
   logic             if_ack_q;
   logic             dm_ack_q;
   logic [IW-1:0]    if_instr_q;
   logic [DW-1:0]    dm_rdata_q;
   logic             err_q;
   logic             tmo_hit_c;

   ma_grant_sel #(.STARVE_LIMIT(STARVE_LIMIT)) u_grant_sel (
      .if_req     (bus.ma_i_if_req),
      .dm_req     (bus.ma_i_dm_req),
      .starve_cnt (starve_cnt_q),
      .owner_c    (gnt_owner_c)
   );

   // Command latched on grant; fetches are always full-word reads.
   always_comb begin
      next_cmd_c = '{we: bus.ma_i_dm_we, mask: bus.ma_i_dm_mask,
                     addr: bus.ma_i_dm_addr, wdata: bus.ma_i_dm_wdata};
      if (gnt_owner_c == OWN_IF)
         next_cmd_c = '{we: 1'b0, mask: {MASK_W{1'b1}},
                        addr: DW'(bus.ma_i_if_addr), wdata: '0};
   end

   assign tmo_hit_c = (tmo_cnt_q == TMO_W'(TIMEOUT - 1));

   always_ff @(posedge ma_clk) begin
      if (ma_rst) begin
         state_q      <= MA_ST_IDLE;
         owner_q      <= OWN_IF;
         cmd_q        <= '0;
         starve_cnt_q <= '0;
         tmo_cnt_q    <= '0;
         mem_req_q    <= 1'b0;
         if_ack_q     <= 1'b0;
         dm_ack_q     <= 1'b0;
         if_instr_q   <= '0;
         dm_rdata_q   <= '0;
         err_q        <= 1'b0;
      end else begin
         if_ack_q <= 1'b0;
         dm_ack_q <= 1'b0;
         case (state_q)
            MA_ST_IDLE: begin
               if (!bus.ma_i_if_req)
                  starve_cnt_q <= '0;
               if (bus.ma_i_if_req || bus.ma_i_dm_req) begin
                  owner_q   <= gnt_owner_c;
                  cmd_q     <= next_cmd_c;
                  mem_req_q <= 1'b1;
                  tmo_cnt_q <= '0;
                  state_q   <= MA_ST_BUSY;
                  if (gnt_owner_c == OWN_IF)
                     starve_cnt_q <= '0;
                  else if (bus.ma_i_if_req && (starve_cnt_q != CNT_W'(STARVE_LIMIT)))
                     starve_cnt_q <= starve_cnt_q + 1'b1;
               end
            end
            MA_ST_BUSY: begin
               // A timed-out access completes with zero data and flags the error.
               if (bus.ma_i_mem_ack || tmo_hit_c) begin
                  mem_req_q <= 1'b0;
                  state_q   <= MA_ST_RESP;
                  if (!bus.ma_i_mem_ack)
                     err_q <= 1'b1;
                  if (owner_q == OWN_IF) begin
                     if_ack_q   <= 1'b1;
                     if_instr_q <= bus.ma_i_mem_ack ? IW'(bus.ma_i_mem_rdata) : '0;
                  end else begin
                     dm_ack_q   <= 1'b1;
                     dm_rdata_q <= bus.ma_i_mem_ack ? bus.ma_i_mem_rdata : '0;
                  end
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + 1'b1;
               end
            end
            MA_ST_RESP: state_q <= MA_ST_IDLE;
            default:    state_q <= MA_ST_IDLE;
         endcase
      end
   end

   assign bus.ma_o_mem_req   = mem_req_q;
   assign bus.ma_o_mem_we    = cmd_q.we;
   assign bus.ma_o_mem_mask  = cmd_q.mask;
   assign bus.ma_o_mem_addr  = cmd_q.addr;
   assign bus.ma_o_mem_wdata = cmd_q.wdata;
   assign bus.ma_o_if_ack    = if_ack_q;
   assign bus.ma_o_if_instr  = if_instr_q;
   assign bus.ma_o_dm_ack    = dm_ack_q;
   assign bus.ma_o_dm_rdata  = dm_rdata_q;
   assign bus.ma_o_err       = err_q;
   assign bus.ma_o_stall     = (bus.ma_i_if_req & ~if_ack_q) | (bus.ma_i_dm_req & ~dm_ack_q);

`ifdef MEM_ARBITER_PERF_CNT_EN
   logic [PERF_W-1:0] if_wait_q;
   logic [PERF_W-1:0] dm_wait_q;

   // Saturating per-port wait counters.
   always_ff @(posedge ma_clk) begin
      if (ma_rst) begin
         if_wait_q <= '0;
         dm_wait_q <= '0;
      end else begin
         if (bus.ma_i_if_req && !if_ack_q && (if_wait_q != {PERF_W{1'b1}}))
            if_wait_q <= if_wait_q + 1'b1;
         if (bus.ma_i_dm_req && !dm_ack_q && (dm_wait_q != {PERF_W{1'b1}}))
            dm_wait_q <= dm_wait_q + 1'b1;
      end
   end

   assign bus.ma_o_if_wait_cnt = if_wait_q;
   assign bus.ma_o_dm_wait_cnt = dm_wait_q;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (STARVE_LIMIT=4, TIMEOUT=64).
// Wait-counter step only when MEM_ARBITER_PERF_CNT_EN is defined.
module tb_mem_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_pass  = 0;
   int   n_total = 0;
   int   n_ack;
   logic seq_dm [0:7];

   mem_arbiter_if bus ();

   mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(64)) dut (
      .ma_clk (clk),
      .ma_rst (rst),
      .bus    (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   initial begin
      bus.ma_i_if_req    = 1'b0;
      bus.ma_i_if_addr   = '0;
      bus.ma_i_dm_req    = 1'b0;
      bus.ma_i_dm_we     = 1'b0;
      bus.ma_i_dm_mask   = '0;
      bus.ma_i_dm_addr   = '0;
      bus.ma_i_dm_wdata  = '0;
      bus.ma_i_mem_ack   = 1'b0;
      bus.ma_i_mem_rdata = '0;

      // Reset state
      tick(); tick();
      chk("rst_mem_req", bus.ma_o_mem_req, 0);
      chk("rst_if_ack",  bus.ma_o_if_ack, 0);
      chk("rst_dm_ack",  bus.ma_o_dm_ack, 0);
      chk("rst_err",     bus.ma_o_err, 0);
      chk("rst_stall",   bus.ma_o_stall, 0);
      bus.ma_i_if_req = 1'b1;
      #1 chk("rst_stall_follows", bus.ma_o_stall, 1);
      bus.ma_i_if_req = 1'b0;
      rst = 1'b0;
      tick();

      // Fetch only, memory acks one cycle after mem_req
      bus.ma_i_if_req  = 1'b1;
      bus.ma_i_if_addr = 32'h10;
      #1 chk("f_stall_T", bus.ma_o_stall, 1);
      tick();
      chk("f_mem_req",  bus.ma_o_mem_req, 1);
      chk("f_mem_addr", bus.ma_o_mem_addr, 32'h10);
      chk("f_mem_we",   bus.ma_o_mem_we, 0);
      chk("f_mem_mask", bus.ma_o_mem_mask, 4'hF);
      chk("f_stall_T1", bus.ma_o_stall, 1);
      chk("f_ack_T1",   bus.ma_o_if_ack, 0);
      bus.ma_i_mem_ack   = 1'b1;
      bus.ma_i_mem_rdata = 32'h2002_0005;
      tick();
      bus.ma_i_mem_ack = 1'b0;
      chk("f_ack_T2",   bus.ma_o_if_ack, 1);
      chk("f_instr",    bus.ma_o_if_instr, 32'h2002_0005);
      chk("f_req_resp", bus.ma_o_mem_req, 0);
      chk("f_stall_T2", bus.ma_o_stall, 0);
      bus.ma_i_if_req = 1'b0;
      tick();
      chk("f_ack_pulse",  bus.ma_o_if_ack, 0);
      chk("f_instr_hold", bus.ma_o_if_instr, 32'h2002_0005);
      chk("f_no_regrant", bus.ma_o_mem_req, 0);

      // Spurious memory ack while idle
      bus.ma_i_mem_ack = 1'b1;
      tick();
      chk("sp_mem_req", bus.ma_o_mem_req, 0);
      chk("sp_acks",    {bus.ma_o_if_ack, bus.ma_o_dm_ack}, 0);
      bus.ma_i_mem_ack = 1'b0;

      // Simultaneous fetch and store: store first, fetch right after
      bus.ma_i_if_req   = 1'b1;
      bus.ma_i_if_addr  = 32'h20;
      bus.ma_i_dm_req   = 1'b1;
      bus.ma_i_dm_we    = 1'b1;
      bus.ma_i_dm_mask  = 4'h3;
      bus.ma_i_dm_addr  = 32'h40;
      bus.ma_i_dm_wdata = 32'hDEAD_BEEF;
      tick();
      chk("s_mem_we",    bus.ma_o_mem_we, 1);
      chk("s_mem_mask",  bus.ma_o_mem_mask, 4'h3);
      chk("s_mem_addr",  bus.ma_o_mem_addr, 32'h40);
      chk("s_mem_wdata", bus.ma_o_mem_wdata, 32'hDEAD_BEEF);
      bus.ma_i_mem_ack   = 1'b1;
      bus.ma_i_mem_rdata = 32'h0BAD_F00D;
      tick();
      bus.ma_i_mem_ack = 1'b0;
      bus.ma_i_dm_req  = 1'b0;
      chk("s_dm_ack",   bus.ma_o_dm_ack, 1);
      chk("s_if_wait",  bus.ma_o_if_ack, 0);
      chk("s_dm_rdata", bus.ma_o_dm_rdata, 32'h0BAD_F00D);
      tick();
      chk("s_idle_req", bus.ma_o_mem_req, 0);
      tick();
      chk("s_f_req",  bus.ma_o_mem_req, 1);
      chk("s_f_addr", bus.ma_o_mem_addr, 32'h20);
      chk("s_f_we",   bus.ma_o_mem_we, 0);
      chk("s_f_mask", bus.ma_o_mem_mask, 4'hF);
      bus.ma_i_mem_ack   = 1'b1;
      bus.ma_i_mem_rdata = 32'h1111_1111;
      tick();
      bus.ma_i_mem_ack = 1'b0;
      bus.ma_i_if_req  = 1'b0;
      chk("s_f_ack",   bus.ma_o_if_ack, 1);
      chk("s_f_instr", bus.ma_o_if_instr, 32'h1111_1111);
      tick();

      // Starvation limiter: data held, fetch pending
      bus.ma_i_dm_req  = 1'b1;
      bus.ma_i_dm_we   = 1'b0;
      bus.ma_i_dm_addr = 32'h80;
      bus.ma_i_if_req  = 1'b1;
      bus.ma_i_if_addr = 32'h30;
      n_ack = 0;
      for (int c = 0; c < 40 && n_ack < 6; c++) begin
         tick();
         bus.ma_i_mem_ack   = bus.ma_o_mem_req;
         bus.ma_i_mem_rdata = 32'h1000 + 32'(c);
         if (bus.ma_o_dm_ack) begin
            seq_dm[n_ack] = 1'b1;
            n_ack++;
         end
         if (bus.ma_o_if_ack) begin
            seq_dm[n_ack] = 1'b0;
            n_ack++;
            bus.ma_i_if_req = 1'b0;
         end
      end
      bus.ma_i_dm_req  = 1'b0;
      bus.ma_i_mem_ack = 1'b0;
      chk("st_acks", 32'(n_ack), 6);
      if (n_ack >= 6) begin
         for (int k = 0; k < 6; k++)
            chk($sformatf("st_owner%0d", k), {31'd0, seq_dm[k]}, (k == 4) ? 0 : 1);
      end
      tick();
      chk("st_idle", bus.ma_o_mem_req, 0);

      // Timeout: memory never acks
      bus.ma_i_dm_req  = 1'b1;
      bus.ma_i_dm_addr = 32'h44;
      for (int k = 0; k < 64; k++) tick();
      chk("to_busy64_req", bus.ma_o_mem_req, 1);
      chk("to_busy64_ack", bus.ma_o_dm_ack, 0);
      chk("to_busy64_err", bus.ma_o_err, 0);
      tick();
      chk("to_ack",   bus.ma_o_dm_ack, 1);
      chk("to_rdata", bus.ma_o_dm_rdata, 0);
      chk("to_err",   bus.ma_o_err, 1);
      chk("to_req",   bus.ma_o_mem_req, 0);
      bus.ma_i_dm_req = 1'b0;
      tick(); tick(); tick();
      chk("to_err_sticky", bus.ma_o_err, 1);

      // Reset while BUSY, memory ack arrives alongside
      bus.ma_i_if_req  = 1'b1;
      bus.ma_i_if_addr = 32'h50;
      tick();
      chk("rb_busy", bus.ma_o_mem_req, 1);
      rst                = 1'b1;
      bus.ma_i_mem_ack   = 1'b1;
      bus.ma_i_mem_rdata = 32'h1234_5678;
      tick();
      chk("rb_mem_req",  bus.ma_o_mem_req, 0);
      chk("rb_if_ack",   bus.ma_o_if_ack, 0);
      chk("rb_instr",    bus.ma_o_if_instr, 0);
      chk("rb_dm_rdata", bus.ma_o_dm_rdata, 0);
      chk("rb_err",      bus.ma_o_err, 0);
      chk("rb_addr",     bus.ma_o_mem_addr, 0);
      chk("rb_mask",     bus.ma_o_mem_mask, 0);
      chk("rb_stall",    bus.ma_o_stall, 1);
      rst              = 1'b0;
      bus.ma_i_if_req  = 1'b0;
      bus.ma_i_mem_ack = 1'b0;
      tick();
      chk("rb_after_ack", bus.ma_o_if_ack, 0);
      chk("rb_after_req", bus.ma_o_mem_req, 0);

`ifdef MEM_ARBITER_PERF_CNT_EN
      // Fetch waits behind a two-cycle data access: 6 wait cycles for fetch, 3 for data
      bus.ma_i_if_req = 1'b1;
      bus.ma_i_dm_req = 1'b1;
      tick();
      tick();
      bus.ma_i_mem_ack = 1'b1;
      tick();
      bus.ma_i_mem_ack = 1'b0;
      bus.ma_i_dm_req  = 1'b0;
      tick();
      tick();
      bus.ma_i_mem_ack = 1'b1;
      tick();
      bus.ma_i_mem_ack = 1'b0;
      bus.ma_i_if_req  = 1'b0;
      chk("pc_if_ack",  bus.ma_o_if_ack, 1);
      chk("pc_if_wait", 32'(bus.ma_o_if_wait_cnt), 6);
      chk("pc_dm_wait", 32'(bus.ma_o_dm_wait_cnt), 3);
      tick();
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
